// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC multiplexed-bus controller: states, op encoding, output bundle.
// Latency: n/a (package only).
// Backpressure: n/a; the helpers here are pure functions.
package rtc_bus_pkg;

  localparam int unsigned FASE_DEF = 4;

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN
  } estado_t;

  typedef enum logic {
    ESCRIBE = 1'b0,
    LEE     = 1'b1
  } op_t;

  // Every output of the controller, kept together so one register holds them all
  typedef struct packed {
    logic       cs_n;
    logic       ad_n;
    logic       wr_n;
    logic       rd_n;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic       listo;
    logic       listo_escribe;
    logic       listo_lee;
  } bus_t;

  localparam bus_t BUS_REPOSO = '{
    cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0,
    ad_out: 8'h00, listo: 1'b1, listo_escribe: 1'b0, listo_lee: 1'b0
  };

  // Fixed walk through the bus phases
  function automatic estado_t siguiente(input estado_t e);
    case (e)
      IDLE:    return A_SET;
      A_SET:   return A_STB;
      A_STB:   return A_HLD;
      A_HLD:   return D_SET;
      D_SET:   return D_STB;
      D_STB:   return D_HLD;
      D_HLD:   return FIN;
      default: return IDLE;
    endcase
  endfunction

  // Output values that belong to a state; evaluated for the state being entered
  function automatic bus_t salida(input estado_t e, input op_t op,
                                  input logic [7:0] dir, input logic [7:0] dat);
    bus_t b;
    b       = BUS_REPOSO;
    b.listo = (e == IDLE);
    case (e)
      A_SET, A_STB, A_HLD: begin
        b.cs_n   = 1'b0;
        b.ad_n   = 1'b0;
        b.ad_oe  = 1'b1;
        b.ad_out = dir;
        b.wr_n   = (e != A_STB);
      end
      D_SET, D_STB, D_HLD: begin
        b.cs_n = 1'b0;
        b.ad_n = 1'b1;
        if (op == ESCRIBE) begin
          b.ad_oe  = 1'b1;
          b.ad_out = dat;
          b.wr_n   = (e != D_STB);
        end else begin
          // Bus released on D_SET entry so the RTC can drive it while rd_n is low
          b.rd_n = (e != D_STB);
        end
      end
      FIN: begin
        b.listo_escribe = (op == ESCRIBE);
        b.listo_lee     = (op == LEE);
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_fase_cnt.sv
// Phase timer: counts cycles spent in the current timed state, flags the last one.
// Latency: fin_fase is combinational from the count, high on the FASE-th cycle.
// Backpressure: none; clr restarts the count on every state change.
module rtc_fase_cnt #(
  parameter int unsigned FASE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic fin_fase
);

  logic [7:0] cnt;

  // Cycles elapsed in the current state, zero on entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign fin_fase = en && (cnt == 8'(FASE - 1));

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed address/data bus controller: one write or read cycle per command.
// Latency: done pulse 6*FASE+1 cycles after the command is accepted.
// Backpressure: commands accepted only while listo=1; anything else is dropped.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned FASE = FASE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_escribir,
  input  logic       cmd_leer,
  input  logic [7:0] direccion,
  input  logic [7:0] dato_escribir,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic [7:0] dato_leido,
  output logic       listo,
  output logic       listo_escribe,
  output logic       listo_lee
);

  estado_t    estado;
  op_t        op_q;
  op_t        op_nuevo;
  logic [7:0] dir_q;
  logic [7:0] dat_q;
  logic [7:0] leido_q;
  bus_t       bus_q;
  logic       en_fase;
  logic       avanza;
  logic       fin_fase;

  // Which states are timed, and when the FSM leaves its current state
  always_comb begin
    en_fase  = (estado != IDLE) && (estado != FIN);
    op_nuevo = cmd_escribir ? ESCRIBE : LEE;
    avanza   = 1'b0;
    case (estado)
      IDLE:    avanza = cmd_escribir || cmd_leer;
      FIN:     avanza = 1'b1;
      default: avanza = fin_fase;
    endcase
  end

  rtc_fase_cnt #(.FASE(FASE)) u_fase_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (avanza),
    .en       (en_fase),
    .fin_fase (fin_fase)
  );

  // Bus-cycle FSM; outputs are loaded with the values of the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado  <= IDLE;
      op_q    <= ESCRIBE;
      dir_q   <= 8'h00;
      dat_q   <= 8'h00;
      leido_q <= 8'h00;
      bus_q   <= BUS_REPOSO;
    end else begin
      case (estado)
        IDLE: begin
          if (avanza) begin
            op_q   <= op_nuevo;
            dir_q  <= direccion;
            dat_q  <= dato_escribir;
            estado <= A_SET;
            bus_q  <= salida(A_SET, op_nuevo, direccion, dato_escribir);
          end
        end
        FIN: begin
          estado <= IDLE;
          bus_q  <= salida(IDLE, op_q, dir_q, dat_q);
        end
        default: begin
          if (avanza) begin
            estado <= siguiente(estado);
            bus_q  <= salida(siguiente(estado), op_q, dir_q, dat_q);
          end
        end
      endcase
      // Sample the RTC's byte at the very end of the read strobe
      if (estado == D_STB && fin_fase && op_q == LEE) begin
        leido_q <= ad_in;
      end
    end
  end

  assign cs_n          = bus_q.cs_n;
  assign ad_n          = bus_q.ad_n;
  assign wr_n          = bus_q.wr_n;
  assign rd_n          = bus_q.rd_n;
  assign ad_out        = bus_q.ad_out;
  assign ad_oe         = bus_q.ad_oe;
  assign listo         = bus_q.listo;
  assign listo_escribe = bus_q.listo_escribe;
  assign listo_lee     = bus_q.listo_lee;
  assign dato_leido    = leido_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl with FASE=4: directed scenarios plus random commands.
module tb_rtc_bus_ctrl;

  localparam int F = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_escribir = 1'b0;
  logic       cmd_leer = 1'b0;
  logic [7:0] direccion = 8'h00;
  logic [7:0] dato_escribir = 8'h00;
  logic [7:0] ad_in;
  logic       cs_n, ad_n, wr_n, rd_n, ad_oe, listo, listo_escribe, listo_lee;
  logic [7:0] ad_out, dato_leido;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;
  logic hold_adin = 1'b0;
  logic [7:0] adin_val = 8'h00;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.FASE(F)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_escribir(cmd_escribir), .cmd_leer(cmd_leer),
    .direccion(direccion), .dato_escribir(dato_escribir), .ad_in(ad_in),
    .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n), .ad_out(ad_out), .ad_oe(ad_oe),
    .dato_leido(dato_leido), .listo(listo), .listo_escribe(listo_escribe), .listo_lee(listo_lee)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // RTC side: random byte each cycle unless a fixed value is requested
  initial begin
    ad_in = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ad_in = hold_adin ? adin_val : 8'($urandom);
    end
  end

  // Reference model: k = cycles since command accept (0 = idle)
  int         k = 0;
  logic       m_w = 1'b0;
  logic [7:0] m_dir = 8'h00, m_dat = 8'h00, m_leido = 8'h00;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        k = 0;
        m_leido = 8'h00;
      end else if (k == 0) begin
        if (cmd_escribir || cmd_leer) begin
          k = 1;
          m_w = cmd_escribir;
          m_dir = direccion;
          m_dat = dato_escribir;
        end
      end else if (k == 6*F + 1) begin
        k = 0;
      end else begin
        if (k == 5*F && !m_w) m_leido = ad_in;
        k = k + 1;
      end
    end
  end

  // Compare every cycle against the model
  initial begin
    logic inbus, fin, e_oe;
    int p;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        inbus = (k >= 1) && (k <= 6*F);
        fin   = (k == 6*F + 1);
        p     = inbus ? (k - 1) / F : 0;
        e_oe  = inbus && ((p < 3) || m_w);
        chk("cs_n",  cs_n,  !inbus);
        chk("ad_n",  ad_n,  !(inbus && p < 3));
        chk("wr_n",  wr_n,  !(inbus && (p == 1 || (p == 4 && m_w))));
        chk("rd_n",  rd_n,  !(inbus && p == 4 && !m_w));
        chk("ad_oe", ad_oe, e_oe);
        if (e_oe) chk("ad_out", ad_out, (p < 3) ? m_dir : m_dat);
        chk("listo", listo, k == 0);
        chk("listo_escribe", listo_escribe, fin && m_w);
        chk("listo_lee", listo_lee, fin && !m_w);
        chk("dato_leido", dato_leido, m_leido);
        chk("strobe_rules", (!wr_n && !rd_n) || (cs_n && (!wr_n || !rd_n)), 1'b0);
      end
    end
  end

  // Per-cycle snapshots of one directed transaction (index 0 = command cycle)
  logic       s_wr[0:63], s_rd[0:63], s_oe[0:63], s_adn[0:63], s_listo[0:63], s_le[0:63], s_ll[0:63];
  logic [7:0] s_out[0:63], s_dat[0:63];

  task automatic txn(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                     input int pc, input logic pw, input logic pr, input int n);
    @(posedge clk);
    #1;
    cmd_escribir = w; cmd_leer = r; direccion = a; dato_escribir = d;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      s_wr[c] = wr_n; s_rd[c] = rd_n; s_oe[c] = ad_oe; s_adn[c] = ad_n;
      s_listo[c] = listo; s_le[c] = listo_escribe; s_ll[c] = listo_lee;
      s_out[c] = ad_out; s_dat[c] = dato_leido;
      @(posedge clk);
      #1;
      cmd_escribir = 1'b0; cmd_leer = 1'b0;
      if (c + 1 == pc) begin cmd_escribir = pw; cmd_leer = pr; end
    end
  endtask

  function automatic int cuenta_le(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(s_le[i]);
    return s;
  endfunction

  function automatic int cuenta_ll(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(s_ll[i]);
    return s;
  endfunction

  function automatic int cuenta_rd_bajo(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(!s_rd[i]);
    return s;
  endfunction

  initial begin
    int r;
    // Reset asserted away from any clock edge
    #1 reset_n = 1'b0;
    #2;
    chk("rst_cs_n", cs_n, 1'b1);  chk("rst_wr_n", wr_n, 1'b1);
    chk("rst_rd_n", rd_n, 1'b1);  chk("rst_ad_n", ad_n, 1'b1);
    chk("rst_ad_oe", ad_oe, 1'b0); chk("rst_ad_out", ad_out, 8'h00);
    chk("rst_dato", dato_leido, 8'h00); chk("rst_listo", listo, 1'b1);
    chk("rst_le", listo_escribe, 1'b0); chk("rst_ll", listo_lee, 1'b0);
    cmp_en = 1'b1;
    #14 reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Write 0x45 to 0x21
    txn(1'b1, 1'b0, 8'h21, 8'h45, -1, 1'b0, 1'b0, 30);
    chk("wr_listo_c0", s_listo[0], 1'b1);
    chk("wr_wr_c4", s_wr[4], 1'b1);   chk("wr_wr_c5", s_wr[5], 1'b0);
    chk("wr_wr_c8", s_wr[8], 1'b0);   chk("wr_wr_c9", s_wr[9], 1'b1);
    chk("wr_addr_c5", s_out[5], 8'h21); chk("wr_adn_c5", s_adn[5], 1'b0);
    chk("wr_wr_c16", s_wr[16], 1'b1); chk("wr_wr_c17", s_wr[17], 1'b0);
    chk("wr_wr_c20", s_wr[20], 1'b0); chk("wr_wr_c21", s_wr[21], 1'b1);
    chk("wr_data_c17", s_out[17], 8'h45); chk("wr_adn_c17", s_adn[17], 1'b1);
    chk("wr_le_c24", s_le[24], 1'b0); chk("wr_le_c25", s_le[25], 1'b1);
    chk("wr_listo_c25", s_listo[25], 1'b0); chk("wr_listo_c26", s_listo[26], 1'b1);

    // Read from 0x41 with the RTC presenting 0x37
    adin_val = 8'h37; hold_adin = 1'b1;
    txn(1'b0, 1'b1, 8'h41, 8'h99, -1, 1'b0, 1'b0, 30);
    hold_adin = 1'b0;
    chk("rd_rd_c16", s_rd[16], 1'b1); chk("rd_rd_c17", s_rd[17], 1'b0);
    chk("rd_rd_c20", s_rd[20], 1'b0); chk("rd_rd_c21", s_rd[21], 1'b1);
    chk("rd_oe_c12", s_oe[12], 1'b1); chk("rd_oe_c13", s_oe[13], 1'b0);
    chk("rd_addr_c1", s_out[1], 8'h41);
    chk("rd_ll_c25", s_ll[25], 1'b1); chk("rd_dato_c25", s_dat[25], 8'h37);

    // Both commands together: write wins, read dropped; dato_leido untouched
    txn(1'b1, 1'b1, 8'h10, 8'hAA, -1, 1'b0, 1'b0, 30);
    chk("sim_le_c25", s_le[25], 1'b1);
    chk("sim_rd_lows", cuenta_rd_bajo(30), 0);
    chk("sim_ll_count", cuenta_ll(30), 0);
    chk("sim_dato_kept", s_dat[25], 8'h37);

    // Read pulsed at cycle 10 of a write is ignored
    txn(1'b1, 1'b0, 8'h21, 8'h45, 10, 1'b0, 1'b1, 30);
    chk("busy_le_count", cuenta_le(30), 1);
    chk("busy_ll_count", cuenta_ll(30), 0);

    // Back-to-back: new command on the first idle cycle after FIN
    txn(1'b1, 1'b0, 8'h21, 8'h45, 26, 1'b1, 1'b0, 56);
    chk("b2b_le_c25", s_le[25], 1'b1); chk("b2b_le_c51", s_le[51], 1'b1);
    chk("b2b_le_count", cuenta_le(56), 2);
    chk("b2b_wr_c30", s_wr[30], 1'b1); chk("b2b_wr_c31", s_wr[31], 1'b0);
    chk("b2b_wr_c43", s_wr[43], 1'b0); chk("b2b_wr_c47", s_wr[47], 1'b1);

    // Reset in the middle of A_STB
    @(posedge clk); #1;
    cmd_escribir = 1'b1; direccion = 8'h21; dato_escribir = 8'h45;
    @(posedge clk); #1;
    cmd_escribir = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_pre_wr_n", wr_n, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_cs_n", cs_n, 1'b1); chk("mid_wr_n", wr_n, 1'b1);
    chk("mid_ad_oe", ad_oe, 1'b0); chk("mid_listo", listo, 1'b1);
    chk("mid_dato", dato_leido, 8'h00);
    #10 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_cs_n", cs_n, 1'b1); chk("post_rst_listo", listo, 1'b1);

    // Random commands, collisions and one asynchronous reset pulse
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      r = int'($urandom_range(0, 15));
      cmd_escribir  = (r < 3);
      cmd_leer      = (r >= 2) && (r < 5);
      direccion     = 8'($urandom);
      dato_escribir = 8'($urandom);
      if (i == 700) begin
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    end
    cmd_escribir = 1'b0; cmd_leer = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("end_idle_listo", listo, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
